// File: rtl/axi_lite_reg_bridge_pkg.sv
// Shared definitions for the AXI4-Lite register bridge:
// response codes, timeout read data and the write/read FSM states.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_RESP
    } r_state_e;

endpackage

// File: rtl/axi_lite_reg_bridge_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
// master drives addresses/data/ready-for-response; slave drives the rest.
interface axi_lite_reg_bridge_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);

    logic [ADDR_BITS-1:0]   awaddr;
    logic                   awvalid;
    logic                   awready;

    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;

    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    logic [ADDR_BITS-1:0]   araddr;
    logic                   arvalid;
    logic                   arready;

    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave to user register-file port bridge.
// Ports: axi_lite_clk/axi_lite_rst (async, active-high), s_axi bus
// (slave modport), user write wr_addr/wr_din/wr_be/wr_en, user read
// rd_addr/rd_en out and rd_dout/rd_ready in. All outputs registered.
module axi_lite_reg_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                   axi_lite_clk,
    input  logic                   axi_lite_rst,
    axi_lite_reg_bridge_if.slave   s_axi,
    output logic [ADDR_BITS-1:0]   wr_addr,
    output logic [DATA_BITS-1:0]   wr_din,
    output logic [DATA_BITS/8-1:0] wr_be,
    output logic                   wr_en,
    output logic [ADDR_BITS-1:0]   rd_addr,
    output logic                   rd_en,
    input  logic [DATA_BITS-1:0]   rd_dout,
    input  logic                   rd_ready
);

    localparam int CNT_W = $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    // ---------------- write path ----------------
    w_state_e               w_state_q, w_state_d;
    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]   wr_din_q, wr_din_d;
    logic [DATA_BITS/8-1:0] wr_be_q, wr_be_d;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_din_d  = wr_din_q;
        wr_be_d   = wr_be_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = {s_axi.awaddr[ADDR_BITS-1:2], 2'b00};
                end
                if (s_axi.wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wr_din_d = s_axi.wdata;
                    wr_be_d  = s_axi.wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_EXEC;
                    wr_en_d   = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else begin
                    // each channel stays open only until it is captured
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_EXEC: begin
                w_state_d = W_RESP;
                bvalid_d  = 1'b1;
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_lite_clk or posedge axi_lite_rst) begin
        if (axi_lite_rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_din_q  <= '0;
            wr_be_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_din_q  <= wr_din_d;
            wr_be_q   <= wr_be_d;
        end
    end

    // ---------------- read path ----------------
    r_state_e             r_state_q, r_state_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        cnt_d     = cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid && arready_q) begin
                    r_state_d = R_ISSUE;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {s_axi.araddr[ADDR_BITS-1:2], 2'b00};
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_ISSUE: begin
                r_state_d = R_WAIT;
                cnt_d     = '0;
            end
            R_WAIT: begin
                if (rd_ready) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_dout;
                    rresp_d   = RESP_OKAY;
                end else if (cnt_q == CNT_LAST) begin
                    // RD_TIMEOUT wait cycles elapsed with no answer
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = DEADBEEF;
                    rresp_d   = RESP_SLVERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_lite_clk or posedge axi_lite_rst) begin
        if (axi_lite_rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            cnt_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            cnt_q     <= cnt_d;
        end
    end

    // low address bits are dropped by word alignment
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign wr_addr = wr_addr_q;
    assign wr_din  = wr_din_q;
    assign wr_be   = wr_be_q;
    assign wr_en   = wr_en_q;
    assign rd_addr = rd_addr_q;
    assign rd_en   = rd_en_q;

endmodule
